seven_segment_capture: RTL
==========================

Name: seven_segment_capture

Overview:
- Receive-side counterpart of the display path: snoops a multiplexed, active-low seven-segment bus (segments plus digit anodes) and recovers the BCD digit shown on each position.
- Each digit is captured only after its pattern has been stable for a settle window. A complete frame of digits is published with a one-cycle strobe.
- Used for self-check and loopback of the clock display and for scoreboard-free board test.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digit positions (HH MM SS).
- SETTLE_CYCLES, 4, consecutive identical samples required before a digit is captured (minimum 1).
- TIMEOUT_CYCLES, 1000000, frame watchdog limit. Used only with CAPTURE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment bus, active-low, bit order {g,f,e,d,c,b,a}.
- an_in  in  NUM_DIGITS  digit enables, active-low. Bit k selects digit k; digit 0 is least significant.
- bcd_out  out  4*NUM_DIGITS  last published frame. Nibble k belongs to digit k.
- frame_valid  out  1  one-cycle pulse when bcd_out updates.
- seg_err  out  1  sticky flag: an unrecognised pattern was captured.
- an_err  out  1  sticky flag: more than one anode was low for a full settle window.
- stale  out  1  watchdog flag. Present only with CAPTURE_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous, active-high.
- Reset values: bcd_out=0, frame_valid=0, seg_err=0, an_err=0, stale=0. Internal: seen mask=0, shadow digits=0, settle counter=0, state=IDLE.
- Input registering: seg_in and an_in are registered once before use. All comparisons act on the registered copies.
- Decode table, exact active-low match:
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9
  - Any other pattern -> 4'hF and sets seg_err.
  - 1111111 (blank) is not captured and is not an error.
- State IDLE:
  - Stays here while no anode is low or the blank pattern is present.
  - Goes to SETTLE when exactly one anode is low, with counter=1.
- State SETTLE:
  - Each cycle with an_in and seg_in unchanged, the counter increments.
  - When the counter reaches SETTLE_CYCLES, write the decoded nibble to shadow digit k, set seen[k], and go to HELD.
  - Any change before that restarts SETTLE with counter=1, or returns to IDLE if the new condition is IDLE-type.
- State HELD:
  - No further writes while the inputs are unchanged.
  - A change goes to SETTLE or IDLE as above.
  - A digit is never written twice per dwell.
- Multiple anodes low: handled as a separate condition with its own counter. If it persists SETTLE_CYCLES, set an_err and capture nothing. State stays IDLE.
- Frame completion:
  - In the cycle after seen becomes all ones, copy the shadow digits to bcd_out and pulse frame_valid for 1 cycle.
  - seen clears in that same cycle.
- Capture coinciding with completion: if a capture lands in the same cycle seen is cleared, that capture sets its seen bit for the new frame. It is not lost.
- Latency: last digit's anode/segments stable at the pins -> frame_valid = SETTLE_CYCLES + 2 cycles (1 input register + settle + publish).
- Sticky flags: seg_err and an_err clear only on reset.
- Reset mid-frame: discards partial shadow and seen contents. bcd_out returns to 0.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - A counter counts cycles since the last frame_valid or reset.
  - At TIMEOUT_CYCLES: set stale, clear seen, restart the count.
  - The next frame_valid clears stale.
- Undefined:
  - No counter and no stale port.
  - An incomplete frame waits indefinitely.

Test Plan:
- Scan digits 0..5 showing 1,2,3,4,5,9 (patterns 1111001, 0100100, 0110000, 0011001, 0010010, 0011000), 8 cycles each -> one frame_valid pulse; bcd_out=24'h954321; no error flags.
- Same scan, but digit 2's pattern changes every 3 cycles with SETTLE_CYCLES=4 -> digit 2 is never captured; no frame_valid until it holds 4 cycles.
- Digit 3 shows 0101010 -> bcd_out nibble 3 = 4'hF; seg_err=1 and stays set across later good frames.
- an_in=111100 held 6 cycles -> an_err=1; no digit written.
- Assert reset after 3 of 6 digits captured, then run a full scan -> exactly one frame_valid, with only post-reset values.
- With CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=100, stop scanning after 4 digits -> stale=1 at cycle 100; the next full scan clears stale and pulses frame_valid.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Snoops a multiplexed active-low seven-segment bus and recovers one BCD digit per anode position.
// Optional frame watchdog (stale output) is built when CAPTURE_TIMEOUT_EN is defined.
module seven_segment_capture #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_valid,
  output logic                    seg_err,
  output logic                    an_err
`ifdef CAPTURE_TIMEOUT_EN
  ,
  output logic                    stale
`endif
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CW = $clog2(SETTLE_EFF + 1);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned LW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_EFF);
  localparam logic [6:0]    BLANK    = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] mcnt, mcnt_nxt;

  logic [6:0]            seg_r, seg_p;
  logic [NUM_DIGITS-1:0] an_r, an_p;

  logic [LW-1:0] low_cnt;
  logic [IW-1:0] digit_idx;
  logic          single, multi, changed, an_changed;
  logic          capture, an_hit, publish, timeout_hit;
  logic [4:0]    dec;

  logic [NUM_DIGITS-1:0]      seen, seen_nxt;
  logic [NUM_DIGITS-1:0][3:0] shadow;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0011000: return {1'b1, 4'd9};
      default:    return {1'b0, 4'hF};
    endcase
  endfunction

  // seg_p/an_p hold the previous registered sample so "unchanged" compares two sampled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_r <= '1;
      seg_p <= '1;
      an_r  <= '1;
      an_p  <= '1;
    end else begin
      seg_r <= seg_in;
      seg_p <= seg_r;
      an_r  <= an_in;
      an_p  <= an_r;
    end
  end

  always_comb begin
    low_cnt   = '0;
    digit_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_r[i]) begin
        low_cnt   = low_cnt + 1'b1;
        digit_idx = i[IW-1:0];
      end
    end
  end

  assign single     = (low_cnt == LW'(1)) && (seg_r != BLANK);
  assign multi      = (low_cnt > LW'(1));
  assign an_changed = (an_r != an_p);
  assign changed    = an_changed || (seg_r != seg_p);
  assign dec        = seg_decode(seg_r);
  assign publish    = &seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE || changed) begin
      if (single) begin
        cnt_nxt   = CNT_ONE;
        state_nxt = (CNT_ONE == CNT_LAST) ? HELD : SETTLE;
      end else begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    end else if (state == SETTLE) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt_nxt == CNT_LAST) state_nxt = HELD;
    end
  end

  // A capture is any entry into HELD; staying in HELD on an unchanged sample never rewrites
  always_comb begin
    capture = (state_nxt == HELD) && ((state != HELD) || changed);
  end

  always_comb begin
    mcnt_nxt = '0;
    if (multi) begin
      if (an_changed)            mcnt_nxt = CNT_ONE;
      else if (mcnt == CNT_LAST) mcnt_nxt = mcnt;
      else                       mcnt_nxt = mcnt + 1'b1;
    end
  end

  assign an_hit = multi && (mcnt_nxt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mcnt <= '0;
    else       mcnt <= mcnt_nxt;
  end

  // Clearing happens before the capture OR so a same-cycle capture opens the next frame
  always_comb begin
    seen_nxt = (publish || timeout_hit) ? '0 : seen;
    if (capture) seen_nxt[digit_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen        <= '0;
      shadow      <= '0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      seen        <= seen_nxt;
      frame_valid <= publish;
      if (publish) bcd_out <= shadow;
      if (capture) begin
        shadow[digit_idx] <= dec[3:0];
        if (!dec[4]) seg_err <= 1'b1;
      end
      if (an_hit) an_err <= 1'b1;
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;

  assign timeout_hit = !publish && (tcnt == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      stale <= 1'b0;
    end else if (publish) begin
      tcnt  <= '0;
      stale <= 1'b0;
    end else if (timeout_hit) begin
      tcnt  <= '0;
      stale <= 1'b1;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
